// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and busy-register scoreboard for the register file write port.
// Handshake: a channel transfers when valid && ready; ready is combinational from valids and rr.
module regfile_wb_arbiter #(
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_dest,
  input  logic [31:0]     alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_dest,
  input  logic [31:0]     ld_data,
  output logic            ld_ready,
  input  logic            md_valid,
  input  logic [4:0]      md_dest,
  input  logic [31:0]     md_data,
  output logic            md_ready,
  input  logic            sb_set,
  input  logic [4:0]      sb_set_addr,
  output logic [NREG-1:0] sb_busy,
  output logic            rf_wren,
  output logic [4:0]      rf_wraddress,
  output logic [31:0]     rf_data
);

  typedef enum logic {RR_LD = 1'b0, RR_MD = 1'b1} rr_e;

  rr_e             r_rr;
  rr_e             w_rr_next;
  logic            w_alu_gnt;
  logic            w_ld_gnt;
  logic            w_md_gnt;
  logic            w_any_gnt;
  logic            w_long_gnt;
  logic [4:0]      w_gnt_dest;
  logic [31:0]     w_gnt_data;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;

  logic            r_wren;
  logic [4:0]      r_wraddress;
  logic [31:0]     r_data;
  logic            r_clr_valid;
  logic [4:0]      r_clr_addr;
  logic [NREG-1:0] r_busy;

  always_ff @(posedge clock) begin
    if (reset) r_rr <= RR_LD;
    else       r_rr <= w_rr_next;
  end

  always_comb begin
    w_rr_next = r_rr;
    if (w_ld_gnt)      w_rr_next = RR_MD;
    else if (w_md_gnt) w_rr_next = RR_LD;
  end

  // ALU always wins; ld/md fall back to the preferred channel only on contention.
  always_comb begin
    w_alu_gnt = 1'b0;
    w_ld_gnt  = 1'b0;
    w_md_gnt  = 1'b0;
    if (!reset) begin
      if (alu_valid)                                   w_alu_gnt = 1'b1;
      else if (ld_valid && (!md_valid || r_rr == RR_LD)) w_ld_gnt  = 1'b1;
      else if (md_valid)                               w_md_gnt  = 1'b1;
    end
  end

  assign w_any_gnt  = w_alu_gnt | w_ld_gnt | w_md_gnt;
  assign w_long_gnt = w_ld_gnt | w_md_gnt;

  always_comb begin
    w_gnt_dest = alu_dest;
    w_gnt_data = alu_data;
    if (w_ld_gnt) begin
      w_gnt_dest = ld_dest;
      w_gnt_data = ld_data;
    end else if (w_md_gnt) begin
      w_gnt_dest = md_dest;
      w_gnt_data = md_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
    end else if (w_any_gnt) begin
      r_wren      <= (w_gnt_dest != 5'd0);
      r_wraddress <= w_gnt_dest;
      r_data      <= w_gnt_data;
    end else begin
      r_wren      <= 1'b0;
    end
  end

  // The clear lags the grant by one edge so busy drops exactly when the file captures the data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clr_valid <= 1'b0;
      r_clr_addr  <= '0;
    end else begin
      r_clr_valid <= w_long_gnt && (w_gnt_dest != 5'd0);
      r_clr_addr  <= w_gnt_dest;
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (sb_set && sb_set_addr != 5'd0) w_set_mask[sb_set_addr] = 1'b1;
    if (r_clr_valid)                   w_clr_mask[r_clr_addr]  = 1'b1;
  end

  // Set applied after clear so a new reservation survives a same-edge retirement.
  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
  end

  assign alu_ready    = w_alu_gnt;
  assign ld_ready     = w_ld_gnt;
  assign md_ready     = w_md_gnt;
  assign sb_busy      = r_busy;
  assign rf_wren      = r_wren;
  assign rf_wraddress = r_wraddress;
  assign rf_data      = r_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed opening sequence then randomized traffic, checked every cycle against a
// behavioural model of grant choice, registered writeback and busy-bit lifetimes.
module tb_regfile_wb_arbiter;

  localparam int NCYC   = 3000;
  localparam int W_NONE = 0;
  localparam int W_ALU  = 1;
  localparam int W_LD   = 2;
  localparam int W_MD   = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, md_valid;
  logic [4:0]  alu_dest, ld_dest, md_dest;
  logic [31:0] alu_data, ld_data, md_data;
  logic        alu_ready, ld_ready, md_ready;
  logic        sb_set;
  logic [4:0]  sb_set_addr;
  logic [31:0] sb_busy;
  logic        rf_wren;
  logic [4:0]  rf_wraddress;
  logic [31:0] rf_data;

  regfile_wb_arbiter #(.NREG(32)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .md_valid(md_valid), .md_dest(md_dest), .md_data(md_data), .md_ready(md_ready),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy),
    .rf_wren(rf_wren), .rf_wraddress(rf_wraddress), .rf_data(rf_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state: what the outputs must show in the current cycle.
  bit          m_rr = 1'b0;
  logic [31:0] m_busy = '0;
  logic        m_wren = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int          clr_cyc[$];
  logic [4:0]  clr_addr[$];
  int          winner;
  int          last_winner = W_NONE;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_and_advance();
    logic [31:0] nb;
    logic [4:0]  d;
    logic [31:0] v;
    winner = W_NONE;
    if (!reset) begin
      if (alu_valid)                 winner = W_ALU;
      else if (ld_valid && md_valid) winner = m_rr ? W_MD : W_LD;
      else if (ld_valid)             winner = W_LD;
      else if (md_valid)             winner = W_MD;
    end
    check_eq("alu_ready",    alu_ready,    winner == W_ALU);
    check_eq("ld_ready",     ld_ready,     winner == W_LD);
    check_eq("md_ready",     md_ready,     winner == W_MD);
    check_eq("rf_wren",      rf_wren,      m_wren);
    check_eq("rf_wraddress", rf_wraddress, m_addr);
    check_eq("rf_data",      rf_data,      m_data);
    check_eq("sb_busy",      sb_busy,      m_busy);

    if (reset) begin
      m_wren = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_rr = 1'b0;
      clr_cyc.delete(); clr_addr.delete();
    end else begin
      nb = m_busy;
      // A long-latency write granted last cycle is being written now; its bit drops at this edge.
      while (clr_cyc.size() > 0 && clr_cyc[0] <= cyc - 1) begin
        nb[clr_addr[0]] = 1'b0;
        void'(clr_cyc.pop_front());
        void'(clr_addr.pop_front());
      end
      if (sb_set && sb_set_addr != 5'd0) nb[sb_set_addr] = 1'b1;
      if (winner != W_NONE) begin
        d = (winner == W_ALU) ? alu_dest : (winner == W_LD) ? ld_dest : md_dest;
        v = (winner == W_ALU) ? alu_data : (winner == W_LD) ? ld_data : md_data;
        m_addr = d;
        m_data = v;
        m_wren = (d != 5'd0);
        if (winner != W_ALU) begin
          m_rr = (winner == W_LD);
          if (d != 5'd0) begin
            clr_cyc.push_back(cyc);
            clr_addr.push_back(d);
          end
        end
      end else begin
        m_wren = 1'b0;
      end
      m_busy = nb;
    end
    last_winner = winner;
    cyc++;
  endtask

  function automatic logic [4:0] rand_dest();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic drive_directed(input int c);
    reset = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0; md_valid = 1'b0;
    sb_set = 1'b0; sb_set_addr = '0;
    alu_dest = 5'd1; alu_data = 32'hA1;
    ld_dest  = 5'd3; ld_data  = 32'hB3;
    md_dest  = 5'd4; md_data  = 32'hC4;
    case (c)
      0, 1:       begin reset = 1'b1; alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1; end
      2:          begin alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h11; end
      3, 4, 5:    begin alu_valid = 1'b1; ld_valid = 1'b1; md_valid = 1'b1; end
      6, 7, 8, 9: begin ld_valid = 1'b1; md_valid = 1'b1; end
      10:         begin sb_set = 1'b1; sb_set_addr = 5'd7; end
      12:         begin md_valid = 1'b1; md_dest = 5'd9; md_data = 32'h99; sb_set = 1'b1; sb_set_addr = 5'd9; end
      13:         begin sb_set = 1'b1; sb_set_addr = 5'd9; end
      14:         begin ld_valid = 1'b1; ld_dest = 5'd0; ld_data = 32'hDEADBEEF; sb_set = 1'b1; sb_set_addr = 5'd0; end
      15:         begin ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h77; end
      16:         begin alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 32'h22; end
      17:         begin reset = 1'b1; end
      default: ;
    endcase
  endtask

  // Producers hold a transaction until it is accepted, then maybe start a new one.
  task automatic drive_random();
    reset = ($urandom_range(0, 49) == 0);
    if (!alu_valid || last_winner == W_ALU) begin
      alu_valid = ($urandom_range(0, 9) < 4);
      alu_dest  = rand_dest();
      alu_data  = $urandom;
    end
    if (!ld_valid || last_winner == W_LD) begin
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_dest  = rand_dest();
      ld_data  = $urandom;
    end
    if (!md_valid || last_winner == W_MD) begin
      md_valid = ($urandom_range(0, 1) == 1);
      md_dest  = rand_dest();
      md_data  = $urandom;
    end
    sb_set      = ($urandom_range(0, 3) == 0);
    sb_set_addr = rand_dest();
  endtask

  initial begin
    drive_directed(0);
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock);
      check_and_advance();
      @(posedge clock);
      #1;
      if (cyc < 20) drive_directed(cyc);
      else          drive_random();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback arbiter and register scoreboard in front of the 32x32 register file write port. It accepts results from three producers (ALU, load unit, mul/div unit) and grants at most one per cycle. It drives a single registered write to the register file and tracks destination registers reserved by outstanding long-latency operations, so decode can stall on hazards. It sits between the execute/memory stages and the register file.

## Interface
Parameters:
- NREG, 32, number of architectural registers; index width is 5 bits; register 0 is hard zero.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- alu_valid  in  1  ALU result present.
- alu_dest  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle.
- ld_valid / ld_dest / ld_data / ld_ready  in/in/in/out  1/5/32/1  load unit result channel, same semantics as the ALU channel.
- md_valid / md_dest / md_data / md_ready  in/in/in/out  1/5/32/1  mul/div result channel, same semantics as the ALU channel.
- sb_set  in  1  decode issues a load or mul/div op this cycle.
- sb_set_addr  in  5  destination register being reserved.
- sb_busy  out  32  bit i = 1 while register i has a pending long-latency write.
- rf_wren  out  1  register file write enable.
- rf_wraddress  out  5  register file write address.
- rf_data  out  32  register file write data.

## Operation
- Handshake: a channel transfers in a cycle where valid=1 and ready=1. Ready is combinational from the valid signals and the arbiter state. A producer holds valid, dest and data stable until it sees ready.
- Priority:
  - ALU always wins: alu_ready = alu_valid.
  - When alu_valid=0, ld and md share the slot round-robin. A 1-bit pointer rr names the preferred channel (0 = ld, 1 = md).
  - If both ld and md are valid, the preferred channel is granted. After any ld or md grant, rr points to the other channel.
  - If only one of ld/md is valid, it is granted and rr is updated the same way.
- At most one ready is high per cycle. A ready is never high while its own valid is 0.
- The granted transfer is registered into the output stage:
  - rf_wraddress and rf_data take the granted dest and data.
  - rf_wren = 1 if the dest is nonzero.
- Register 0 rules:
  - A transfer with dest=0 is still accepted (ready=1), but rf_wren=0.
  - sb_set with sb_set_addr=0 is ignored.
- In cycles with no grant, rf_wren=0. rf_wraddress and rf_data hold their previous values.
- Scoreboard:
  - On sb_set (addr nonzero), the busy bit is set at the next edge.
  - An ld or md transfer clears its dest busy bit at the edge that ends the rf_wren cycle, i.e. the edge at which the register file captures the data.
  - ALU transfers never clear busy bits.
- Simultaneous set and clear of the same register in the same edge: set wins, so the bit stays 1. This covers an old op retiring while a new op reserves the same register.
- sb_set on a register that is already busy leaves it busy. No reservation count is kept; decode must not issue a second long-latency op to a busy register.
- Reset values:
  - rf_wren=0, rf_wraddress=0, rf_data=0.
  - sb_busy=0, rr=0 (ld preferred).
  - The pending-clear pipeline is emptied.
- Reset mid-operation:
  - An in-flight output write is dropped: rf_wren=0 in the cycle after reset.
  - All ready outputs are 0 while reset=1.

## Timing
- Grant (ready) is combinational in the request cycle N.
- rf_wren, rf_wraddress and rf_data are valid in cycle N+1. The register file is written at the end of N+1.
- The busy bit for an ld/md dest is 1 through cycle N+1 and 0 from cycle N+2. This matches the first cycle in which an asynchronous register file read returns the new value.
- sb_set in cycle M gives sb_busy=1 from cycle M+1.
- Throughput: one writeback per cycle. Worst-case wait for ld/md under no ALU traffic is 1 cycle. ALU traffic can delay ld/md indefinitely; the pipeline guarantees ALU bubbles.

## Test plan
- Reset: hold reset for 2 cycles with all valids=1 -> all ready=0, rf_wren=0, sb_busy=0. First cycle after reset, alu_valid=1 with dest=5 and data=0x11 -> alu_ready=1; next cycle rf_wren=1, rf_wraddress=5, rf_data=0x11.
- Priority: alu, ld and md all valid for 3 cycles (ld dest=3, md dest=4) -> only alu_ready high each cycle. Then drop alu -> ld granted, then md, then ld (rr alternation).
- Scoreboard: sb_set addr=7 in cycle 0 -> sb_busy[7]=1 from cycle 1. ld dest=7 granted in cycle 4 -> rf_wren=1 in cycle 5; sb_busy[7]=1 in cycle 5 and 0 in cycle 6.
- Set/clear collision: md dest=9 granted in cycle N, and sb_set addr=9 in cycle N+1 -> sb_busy[9] stays 1 at N+2 and after.
- Register 0: ld_valid=1 with dest=0 and data=0xDEADBEEF -> ld_ready=1, next cycle rf_wren=0. sb_set addr=0 -> sb_busy[0] stays 0.
- Reset mid-write: a grant in cycle N and reset=1 in cycle N+1 -> rf_wren=0 in N+2, and all busy bits 0 in N+2.
